// File: rtl/fifo_wr_rr_arbiter.sv
// Round-robin burst arbiter sharing one synchronous FIFO write port among N_REQ producers.
// Optional stall watchdog enabled by `define FIFO_ARB_WDOG_EN.
module fifo_wr_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 16,
  parameter int ID_W      = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    fifo_wr_en,
  output logic [DATA_W-1:0]       fifo_wr_data,
  input  logic                    fifo_wr_full,
  input  logic                    fifo_almost_full,
  output logic [N_REQ-1:0]        grant,
  output logic [ID_W-1:0]         grant_id,
  output logic                    wdog_timeout
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  if (N_REQ < 2 || N_REQ > 8 || BURST_LEN < 1 || BURST_LEN > 256 ||
      TIMEOUT < 1 || (1 << ID_W) < N_REQ) begin : g_cfg_err
    $error("fifo_wr_rr_arbiter: illegal parameter set");
  end

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  gid_q, gid_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             to_q, to_d;

  logic             pick_found;
  logic [ID_W-1:0]  pick_id;
  logic             in_burst;
  logic             owner_valid;
  logic             owner_last;
  logic             accept;
  logic             burst_end;
  logic             wdog_fire;
  logic [ID_W-1:0]  next_ptr;

  // Search upward from rr_ptr with wrap; first valid index wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  assign in_burst    = (state_q == S_BURST);
  assign owner_valid = |(req_valid & grant_q);
  assign owner_last  = |(req_last & grant_q);

  assign req_ready  = in_burst ? (grant_q & {N_REQ{~fifo_wr_full}}) : '0;
  assign fifo_wr_en = in_burst & owner_valid & ~fifo_wr_full;

  always_comb begin
    fifo_wr_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gid_q == ID_W'(i)) begin
        fifo_wr_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign accept    = fifo_wr_en;
  assign burst_end = accept &
                     (owner_last | (beat_q == CNT_W'(BURST_LEN - 1)));
  assign next_ptr  = (gid_q == ID_W'(N_REQ - 1)) ?
                     '0 : gid_q + ID_W'(1);

`ifdef FIFO_ARB_WDOG_EN
  localparam int ST_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [ST_W-1:0] stall_q, stall_d;

  // Only an owner with nothing to send counts; FIFO back-pressure does not.
  always_comb begin
    stall_d   = stall_q;
    wdog_fire = 1'b0;
    if (!in_burst || accept) begin
      stall_d = '0;
    end else if (!owner_valid) begin
      if (stall_q == ST_W'(TIMEOUT - 1)) begin
        wdog_fire = 1'b1;
        stall_d   = '0;
      end else begin
        stall_d = stall_q + ST_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  assign wdog_fire = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gid_d    = gid_q;
    grant_d  = grant_q;
    beat_d   = beat_q;
    to_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found && !fifo_almost_full) begin
          state_d = S_BURST;
          gid_d   = pick_id;
          grant_d = N_REQ'(1) << pick_id;
          beat_d  = '0;
        end
      end
      S_BURST: begin
        if (burst_end || wdog_fire) begin
          state_d  = S_IDLE;
          rr_ptr_d = next_ptr;
          grant_d  = '0;
          beat_d   = '0;
          to_d     = wdog_fire;
        end else if (accept) begin
          beat_d = beat_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      grant_q  <= '0;
      beat_q   <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      grant_q  <= grant_d;
      beat_q   <= beat_d;
      to_q     <= to_d;
    end
  end

  assign grant        = grant_q;
  assign grant_id     = gid_q;
  assign wdog_timeout = to_q;

endmodule
